rom_arb: RTL and testbench

- Sits directly downstream of the mapper dispatch block. Consumes its PRG ROM port (promaddr/promreq) and CHR ROM port (cromaddr/cromreq).
- Serialises both onto one external 8-bit ROM memory port using a req/ack handshake.
- Returns read data and a one-cycle ack to each channel.
- Round-robin arbitration; a watchdog flags a hung memory.

---
 rtl/rom_arb_pkg.sv | 26 ++
 rtl/rom_arb_wdog.sv | 39 +++
 rtl/rom_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_rom_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared definitions for the PRG/CHR ROM arbiter.
//   - state_t      : arbiter FSM state encoding (IDLE / BUSY / DONE)
//   - CH_PRG/CH_CHR: channel identifiers used for grant and last-served tracking
//   - DEF_*        : default address width, CHR byte offset and watchdog limit
//   - rr_pick      : round-robin choice for a tie given the last-served channel
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic CH_PRG = 1'b0;
  localparam logic CH_CHR = 1'b1;

  localparam int unsigned DEF_AW       = 21;
  localparam logic [21:0] DEF_CHR_BASE = 22'h200000;
  localparam int unsigned DEF_TIMEOUT  = 255;

  // On a tie the channel that was not served last wins.
  function automatic logic rr_pick(input logic last_ch);
    return ~last_ch;
  endfunction

endpackage

// File: rtl/rom_arb_wdog.sv
// rom_arb_wdog: loadable watchdog counter for one outstanding memory access.
// Ports:
//   clk       in  system clock
//   resetn    in  asynchronous active-low reset
//   i_load    in  start of an access; counter is set to 1 (first outstanding cycle)
//   i_en      in  access still outstanding; counter advances one step per cycle
//   o_expired out counter has reached TIMEOUT outstanding cycles
module rom_arb_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1'b1);

  logic [CW-1:0] r_count;

  // Outstanding-cycle counter; saturates at LIMIT so it can never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= ONE;
    end else if (i_en && (r_count < LIMIT)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/rom_arb.sv
// rom_arb: serialises the mapper's PRG and CHR ROM read ports onto a single
// external 8-bit ROM port (req/ack handshake), round-robin on ties, with a
// watchdog that forces completion (data 8'hFF, sticky timeout) on a hung memory.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   promaddr/promreq -> promack/promdata   PRG channel (level req, 1-cycle ack)
//   cromaddr/cromreq -> cromack/cromdata   CHR channel (level req, 1-cycle ack)
//   memaddr/memreq   <- memack/memrdata    external ROM port
//   timeout                        sticky watchdog-expiry flag
// Optional build macro ROM_CACHE_EN: one-entry per-channel address tag; a
// repeated read of the last completed address is answered without memory.
module rom_arb
  import rom_arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter logic [AW:0] CHR_BASE = (AW+1)'(DEF_CHR_BASE),
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] promaddr,
  input  logic          promreq,
  output logic          promack,
  output logic [7:0]    promdata,
  input  logic [AW-1:0] cromaddr,
  input  logic          cromreq,
  output logic          cromack,
  output logic [7:0]    cromdata,
  output logic [AW:0]   memaddr,
  output logic          memreq,
  input  logic          memack,
  input  logic [7:0]    memrdata,
  output logic          timeout
);

  state_t      r_state;
  logic        r_ch;
  logic        r_last;
  logic [AW:0] r_memaddr;
  logic        r_memreq;
  logic        r_promack;
  logic        r_cromack;
  logic [7:0]  r_promdata;
  logic [7:0]  r_cromdata;
  logic        r_timeout;

  state_t      w_state_nxt;
  logic        w_ch_nxt;
  logic        w_last_nxt;
  logic [AW:0] w_memaddr_nxt;
  logic        w_memreq_nxt;
  logic        w_promack_nxt;
  logic        w_cromack_nxt;
  logic [7:0]  w_promdata_nxt;
  logic [7:0]  w_cromdata_nxt;
  logic        w_timeout_nxt;
  logic [7:0]  w_rdata;

  logic        w_gnt_vld;
  logic        w_gnt_ch;
  logic [AW:0] w_gnt_addr;
  logic        w_hit;
  logic        w_wd_load;
  logic        w_wd_en;
  logic        w_expired;

  rom_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_wd_load),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  // Channel selection for the current IDLE sample.
  always_comb begin
    w_gnt_vld = promreq | cromreq;
    if (promreq && cromreq) begin
      w_gnt_ch = rr_pick(r_last);
    end else if (cromreq) begin
      w_gnt_ch = CH_CHR;
    end else begin
      w_gnt_ch = CH_PRG;
    end
  end

  // CHR ROM sits at CHR_BASE in the external space; no wrap check on the add.
  assign w_gnt_addr = (w_gnt_ch == CH_CHR) ? ({1'b0, cromaddr} + CHR_BASE)
                                           : {1'b0, promaddr};

`ifdef ROM_CACHE_EN
  logic [AW:0] r_tag_addr [2];
  logic [1:0]  r_tag_vld;

  assign w_hit = r_tag_vld[w_gnt_ch] && (r_tag_addr[w_gnt_ch] == w_gnt_addr);

  // Per-channel tag: filled on a real memory completion, dropped on that channel's timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag_addr[0] <= '0;
      r_tag_addr[1] <= '0;
      r_tag_vld     <= 2'b00;
    end else if ((r_state == ST_BUSY) && memack) begin
      r_tag_addr[r_ch] <= r_memaddr;
      r_tag_vld[r_ch]  <= 1'b1;
    end else if ((r_state == ST_BUSY) && w_expired) begin
      r_tag_vld[r_ch] <= 1'b0;
    end else begin
      r_tag_vld <= r_tag_vld;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Next-state and next-output decode for the arbiter FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_ch_nxt       = r_ch;
    w_last_nxt     = r_last;
    w_memaddr_nxt  = r_memaddr;
    w_memreq_nxt   = r_memreq;
    w_promack_nxt  = 1'b0;
    w_cromack_nxt  = 1'b0;
    w_promdata_nxt = r_promdata;
    w_cromdata_nxt = r_cromdata;
    w_timeout_nxt  = r_timeout;
    w_rdata        = 8'hFF;
    w_wd_load      = 1'b0;
    w_wd_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld && w_hit) begin
          // Tag hit: answer from the held data register, memory untouched.
          w_ch_nxt    = w_gnt_ch;
          w_last_nxt  = w_gnt_ch;
          w_state_nxt = ST_DONE;
          if (w_gnt_ch == CH_CHR) begin
            w_cromack_nxt = 1'b1;
          end else begin
            w_promack_nxt = 1'b1;
          end
        end else if (w_gnt_vld) begin
          w_ch_nxt      = w_gnt_ch;
          w_memaddr_nxt = w_gnt_addr;
          w_memreq_nxt  = 1'b1;
          w_wd_load     = 1'b1;
          w_state_nxt   = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_wd_en = 1'b1;
        if (memack || w_expired) begin
          // A memack in the expiry cycle is a normal completion.
          w_rdata       = memack ? memrdata : 8'hFF;
          w_memreq_nxt  = 1'b0;
          w_last_nxt    = r_ch;
          w_state_nxt   = ST_DONE;
          if (!memack) begin
            w_timeout_nxt = 1'b1;
          end else begin
            w_timeout_nxt = r_timeout;
          end
          if (r_ch == CH_CHR) begin
            w_cromack_nxt  = 1'b1;
            w_cromdata_nxt = w_rdata;
          end else begin
            w_promack_nxt  = 1'b1;
            w_promdata_nxt = w_rdata;
          end
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Turnaround: requesters drop req here, so requests are not sampled.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_memreq_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; last-served resets to CHR so PRG wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_ch       <= CH_PRG;
      r_last     <= CH_CHR;
      r_memaddr  <= '0;
      r_memreq   <= 1'b0;
      r_promack  <= 1'b0;
      r_cromack  <= 1'b0;
      r_promdata <= 8'h00;
      r_cromdata <= 8'h00;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_last     <= w_last_nxt;
      r_memaddr  <= w_memaddr_nxt;
      r_memreq   <= w_memreq_nxt;
      r_promack  <= w_promack_nxt;
      r_cromack  <= w_cromack_nxt;
      r_promdata <= w_promdata_nxt;
      r_cromdata <= w_cromdata_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign promack  = r_promack;
  assign cromack  = r_cromack;
  assign promdata = r_promdata;
  assign cromdata = r_cromdata;
  assign memaddr  = r_memaddr;
  assign memreq   = r_memreq;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_rom_arb.sv
// tb_rom_arb: randomized self-checking bench for rom_arb against a
// transaction-level model (grant rule, address map, latency, data, sticky
// timeout, optional per-channel tag). Build with ROM_CACHE_EN to model the tag.
module tb_rom_arb;

  localparam int          AW    = 21;
  localparam int          TMO   = 8;
  localparam logic [21:0] CBASE = 22'h200000;
`ifdef ROM_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic [AW-1:0] promaddr = '0;
  logic [AW-1:0] cromaddr = '0;
  logic          promreq  = 1'b0;
  logic          cromreq  = 1'b0;
  logic          memack   = 1'b0;
  logic [7:0]    memrdata = 8'h00;
  logic          promack, cromack, memreq, timeout;
  logic [7:0]    promdata, cromdata;
  logic [AW:0]   memaddr;

  int         mem_lat  = 1;
  int         mem_cnt  = 0;
  logic [7:0] mem_data = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_last_chr;
  bit          m_tmo;
  logic [7:0]  m_data    [2];
  logic [21:0] m_tag     [2];
  bit          m_tag_vld [2];
  logic [20:0] m_prev    [2];

  rom_arb #(.AW(AW), .CHR_BASE(CBASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .promaddr(promaddr), .promreq(promreq), .promack(promack), .promdata(promdata),
    .cromaddr(cromaddr), .cromreq(cromreq), .cromack(cromack), .cromdata(cromdata),
    .memaddr(memaddr), .memreq(memreq), .memack(memack), .memrdata(memrdata),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External memory: acks mem_lat cycles after memreq first goes high.
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      #1;
      if (!resetn) begin
        memack  = 1'b0;
        mem_cnt = 0;
      end else if (memack) begin
        memack  = 1'b0;
        mem_cnt = 0;
      end else if (memreq) begin
        if (mem_cnt == mem_lat) begin
          memack   = 1'b1;
          memrdata = mem_data;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_chr = 1'b1;
    m_tmo      = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_data[c]    = 8'h00;
      m_tag[c]     = 22'h0;
      m_tag_vld[c] = 1'b0;
      m_prev[c]    = 21'h0;
    end
  endtask

  function automatic logic [21:0] ext_addr(input bit ch, input logic [20:0] a);
    return ch ? (CBASE + {1'b0, a}) : {1'b0, a};
  endfunction

  function automatic bit model_hit(input bit ch, input logic [21:0] a);
    return CACHE_ON && m_tag_vld[ch] && (m_tag[ch] == a);
  endfunction

  task automatic model_complete(input bit ch, input logic [21:0] a, input bit hit,
                                input bit tmo, input logic [7:0] d);
    m_last_chr = ch;
    if (tmo) begin
      m_data[ch]    = 8'hFF;
      m_tmo         = 1'b1;
      m_tag_vld[ch] = 1'b0;
    end else if (!hit) begin
      m_data[ch]    = d;
      m_tag[ch]     = a;
      m_tag_vld[ch] = 1'b1;
    end else begin
      m_data[ch] = m_data[ch];
    end
  endtask

  // One transaction from IDLE; returns with the DUT back in IDLE.
  task automatic do_txn(input bit rp, input bit rc, input logic [20:0] pa,
                        input logic [20:0] ca, input int lat, input logic [7:0] d);
    bit          ch;
    bit          hit;
    bit          tmo;
    logic [21:0] ea;
    int          exp_ack, exp_reqc;
    int          first_req, req_cycles, ack_cyc;
    logic        got_ch;
    logic [7:0]  got_d;
    logic [21:0] got_addr;
    ch  = (rp && rc) ? !m_last_chr : rc;
    ea  = ext_addr(ch, ch ? ca : pa);
    hit = model_hit(ch, ea);
    tmo = !hit && (lat >= TMO);
    exp_ack  = hit ? 1 : (tmo ? TMO + 1 : lat + 2);
    exp_reqc = hit ? 0 : (tmo ? TMO : lat + 1);
    promaddr = pa; cromaddr = ca; promreq = rp; cromreq = rc;
    mem_lat = lat; mem_data = d;
    first_req = -1; req_cycles = 0; ack_cyc = -1;
    got_ch = 1'b0; got_d = 8'h00; got_addr = 22'h0;
    for (int i = 1; i <= 40 && ack_cyc < 0; i++) begin
      tick();
      if (memreq) begin
        req_cycles++;
        if (first_req < 0) begin
          first_req = i;
          got_addr  = memaddr;
        end
      end
      check("ack_excl", 32'(promack & cromack), 32'd0);
      if (promack || cromack) begin
        ack_cyc = i;
        got_ch  = cromack;
        got_d   = cromack ? cromdata : promdata;
        promreq = 1'b0;
        cromreq = 1'b0;
      end
    end
    promreq = 1'b0;
    cromreq = 1'b0;
    model_complete(ch, ea, hit, tmo, d);
    m_prev[0] = pa;
    m_prev[1] = ca;
    check("ack_seen",      32'(ack_cyc > 0), 32'd1);
    check("ack_ch",        32'(got_ch), 32'(ch));
    check("ack_cycle",     32'(ack_cyc), 32'(exp_ack));
    check("ack_data",      32'(got_d), 32'(m_data[ch]));
    check("memreq_cycles", 32'(req_cycles), 32'(exp_reqc));
    if (!hit) begin
      check("memreq_start", 32'(first_req), 32'd1);
      check("memaddr",      32'(got_addr), 32'(ea));
    end else begin
      check("hit_no_req",   32'(first_req), 32'hFFFF_FFFF);
    end
    check("timeout_flag", 32'(timeout), 32'(m_tmo));
    tick();
    check("ack_single", 32'({promack, cromack}), 32'd0);
    check("prg_hold",   32'(promdata), 32'(m_data[0]));
    check("chr_hold",   32'(cromdata), 32'(m_data[1]));
  endtask

  // Both channels held high: strict alternation, fixed turnaround spacing.
  task automatic b2b();
    bit          exp_ch;
    int          acks, last_ack;
    logic        prev_req;
    logic [21:0] t;
    t = m_tag[1] - CBASE;
    promaddr = m_tag[0][20:0] + 21'd1;
    cromaddr = t[20:0] + 21'd1;
    promreq = 1'b1; cromreq = 1'b1;
    mem_lat = 1; mem_data = 8'($urandom);
    exp_ch = !m_last_chr;
    acks = 0; last_ack = -1; prev_req = 1'b0;
    for (int i = 1; i <= 60 && acks < 4; i++) begin
      tick();
      check("b2b_excl", 32'(promack & cromack), 32'd0);
      if (memreq && !prev_req) begin
        check("b2b_addr", 32'(memaddr), 32'(ext_addr(exp_ch, exp_ch ? cromaddr : promaddr)));
        if (last_ack > 0) check("b2b_gap", 32'(i - last_ack), 32'd2);
        else              check("b2b_first", 32'(i), 32'd1);
      end
      prev_req = memreq;
      if (promack || cromack) begin
        check("b2b_ch",   32'(cromack), 32'(exp_ch));
        check("b2b_data", 32'(cromack ? cromdata : promdata), 32'(mem_data));
        model_complete(exp_ch, ext_addr(exp_ch, exp_ch ? cromaddr : promaddr), 1'b0, 1'b0, mem_data);
        if (exp_ch) cromaddr = cromaddr + 21'd1;
        else        promaddr = promaddr + 21'd1;
        mem_data = 8'($urandom);
        exp_ch = !exp_ch;
        acks++;
        last_ack = i;
      end
    end
    promreq = 1'b0;
    cromreq = 1'b0;
    check("b2b_count", 32'(acks), 32'd4);
    check("b2b_tmo",   32'(timeout), 32'(m_tmo));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit          rp, rc, reuse;
    int          mode, lat;
    logic [20:0] pa, ca;
    model_reset();
    repeat (3) tick();
    check("rst_memreq",   32'(memreq), 32'd0);
    check("rst_memaddr",  32'(memaddr), 32'd0);
    check("rst_acks",     32'({promack, cromack}), 32'd0);
    check("rst_promdata", 32'(promdata), 32'd0);
    check("rst_cromdata", 32'(cromdata), 32'd0);
    check("rst_timeout",  32'(timeout), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed PRG-only and CHR-only reads
    do_txn(1'b1, 1'b0, 21'h00123, 21'h0, 3, 8'hA5);
    do_txn(1'b0, 1'b1, 21'h0, 21'h01FFF, 2, 8'h5A);
    b2b();
    // memack in the expiry cycle is a normal completion
    do_txn(1'b1, 1'b0, 21'($urandom), 21'h0, TMO - 1, 8'($urandom));
    // Hung memory, then timeout must stay sticky
    do_txn(1'b0, 1'b1, 21'h0, 21'($urandom), 1000, 8'h11);
    do_txn(1'b1, 1'b1, 21'($urandom), 21'($urandom), 1, 8'($urandom));
    do_txn(1'b1, 1'b1, 21'($urandom), 21'($urandom), 4, 8'($urandom));

    // Stray memack while idle is ignored
    #2;
    memack = 1'b1;
    memrdata = 8'h3C;
    tick();
    check("idle_memack_acks", 32'({promack, cromack}), 32'd0);
    check("idle_memack_req",  32'(memreq), 32'd0);
    tick();
    check("idle_memack_prg",  32'(promdata), 32'(m_data[0]));
    check("idle_memack_chr",  32'(cromdata), 32'(m_data[1]));

    // Repeat read, other address, read after timeout, repeat again
    do_txn(1'b1, 1'b0, 21'h00040, 21'h0, 2, 8'h77);
    do_txn(1'b1, 1'b0, 21'h00040, 21'h0, 2, 8'h88);
    do_txn(1'b1, 1'b0, 21'h00041, 21'h0, 1, 8'h99);
    do_txn(1'b1, 1'b0, 21'h00041, 21'h0, 1000, 8'h00);
    do_txn(1'b1, 1'b0, 21'h00041, 21'h0, 3, 8'h5C);
    do_txn(1'b1, 1'b0, 21'h00041, 21'h0, 3, 8'h6D);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      mode  = $urandom_range(0, 2);
      rp    = (mode != 1);
      rc    = (mode != 0);
      reuse = ($urandom_range(0, 2) == 0);
      pa    = reuse ? m_prev[0] : 21'($urandom);
      ca    = reuse ? m_prev[1] : 21'($urandom);
      lat   = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(1, TMO - 1);
      do_txn(rp, rc, pa, ca, lat, 8'($urandom));
    end

    // Asynchronous reset in the middle of an access
    check("tmo_before_rst", 32'(timeout), 32'(m_tmo));
    promaddr = 21'($urandom);
    promreq  = 1'b1;
    mem_lat  = 1000;
    for (int i = 0; i < 5 && !memreq; i++) tick();
    check("rst_busy_req", 32'(memreq), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_memreq",  32'(memreq), 32'd0);
    check("arst_acks",    32'({promack, cromack}), 32'd0);
    check("arst_timeout", 32'(timeout), 32'd0);
    check("arst_promdat", 32'(promdata), 32'd0);
    promreq = 1'b0;
    tick();
    resetn = 1'b1;
    model_reset();
    do_txn(1'b1, 1'b1, 21'($urandom), 21'($urandom), 2, 8'($urandom));
    do_txn(1'b1, 1'b1, 21'($urandom), 21'($urandom), 1, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
